// File: rtl/piso_serializer.sv
// piso_serializer
//
// Parallel-in / serial-out serializer with a valid/ready input handshake.
// A WIDTH-bit word is accepted and shifted out one bit per shift_en tick,
// LSB-first or MSB-first. Frame markers (sof/eof) flag the first and last
// bits of each word. Back-to-back words are sent with no gap between frames.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  0: bit 0 leaves first, 1: bit WIDTH-1 leaves first
//   IDLE_LEVEL level driven on so while no frame is active
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   shift_en  in   bit-rate tick; a bit advances only on edges where it is 1
//   flush     in   synchronous abort of the current frame
//   in_valid  in   in_data holds a word
//   in_data   in   parallel word (WIDTH bits)
//   in_ready  out  word is accepted on this edge if in_valid is also high
//   so        out  serial data (registered)
//   so_valid  out  so carries a frame bit (registered)
//   sof       out  so carries the first bit of a word (registered)
//   eof       out  so carries the last bit of a word (registered)

module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 0,
  parameter int unsigned IDLE_LEVEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             so,
  output logic             so_valid,
  output logic             sof,
  output logic             eof
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST     = CW'(WIDTH - 1);
  localparam logic           IDLE_BIT = (IDLE_LEVEL != 0);
  localparam logic           MSB_MODE = (MSB_FIRST != 0);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_so;
  logic             r_so_valid;
  logic             r_sof;
  logic             r_eof;

  logic             w_last;
  logic             w_word_end;
  logic             w_ready;
  logic             w_load;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] w_shifted;
  logic             w_first_bit;
  logic             w_next_bit;

  // The bit currently on so is always the outgoing end of r_sr; shifting
  // moves the next bit into that position and fills the far end with 0.
  assign w_last      = (r_cnt == LAST);
  assign w_word_end  = (r_state == ST_SHIFT) && shift_en && w_last;
  assign w_cnt_next  = r_cnt + 1'b1;
  assign w_shifted   = MSB_MODE ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
  assign w_first_bit = MSB_MODE ? in_data[WIDTH-1] : in_data[0];
  assign w_next_bit  = MSB_MODE ? w_shifted[WIDTH-1] : w_shifted[0];

  // Ready is combinational so that a new word can be taken on the very edge
  // that retires the last bit of the current one; flush and reset block it.
  assign w_ready  = !rst && !flush && ((r_state == ST_IDLE) || w_word_end);
  assign w_load   = w_ready && in_valid;
  assign in_ready = w_ready;

  // flush outranks loading and shifting; a load already covers the
  // end-of-word case, so the shift branch only has to handle the idle return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_so       <= IDLE_BIT;
      r_so_valid <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
    end else if (flush) begin
      r_state    <= ST_IDLE;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_so       <= IDLE_BIT;
      r_so_valid <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
    end else if (w_load) begin
      r_state    <= ST_SHIFT;
      r_sr       <= in_data;
      r_cnt      <= '0;
      r_so       <= w_first_bit;
      r_so_valid <= 1'b1;
      r_sof      <= 1'b1;
      r_eof      <= 1'b0;
    end else if ((r_state == ST_SHIFT) && shift_en) begin
      if (w_last) begin
        r_state    <= ST_IDLE;
        r_sr       <= '0;
        r_cnt      <= '0;
        r_so       <= IDLE_BIT;
        r_so_valid <= 1'b0;
        r_sof      <= 1'b0;
        r_eof      <= 1'b0;
      end else begin
        r_sr  <= w_shifted;
        r_cnt <= w_cnt_next;
        r_so  <= w_next_bit;
        r_sof <= 1'b0;
        r_eof <= (w_cnt_next == LAST);
      end
    end
  end

  assign so       = r_so;
  assign so_valid = r_so_valid;
  assign sof      = r_sof;
  assign eof      = r_eof;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
//
// Drives three serializer instances from shared control signals:
//   u0: WIDTH=8, LSB-first, idle level 0
//   u1: WIDTH=8, MSB-first, idle level 0
//   u2: WIDTH=2, LSB-first, idle level 1
// A word-level model (busy flag, held word, bit index) predicts every output.

module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       shiftEn;
  logic       flush;
  logic       inValid;
  logic [7:0] dIn [3];

  logic oRdy [3];
  logic oSo  [3];
  logic oVld [3];
  logic oSof [3];
  logic oEof [3];

  int nCompared = 0;
  int nMismatch = 0;
  bit checkEn = 1'b0;

  // Model configuration and state, one slot per instance.
  int         mW    [3] = '{8, 8, 2};
  bit         mMsb  [3] = '{1'b0, 1'b1, 1'b0};
  logic       mIdle [3] = '{1'b0, 1'b0, 1'b1};
  bit         mBusy [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] mWord [3] = '{8'h00, 8'h00, 8'h00};
  int         mIdx  [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(0)) u0 (
    .clk(clk), .rst(rst), .shift_en(shiftEn), .flush(flush),
    .in_valid(inValid), .in_data(dIn[0]), .in_ready(oRdy[0]),
    .so(oSo[0]), .so_valid(oVld[0]), .sof(oSof[0]), .eof(oEof[0])
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(0)) u1 (
    .clk(clk), .rst(rst), .shift_en(shiftEn), .flush(flush),
    .in_valid(inValid), .in_data(dIn[1]), .in_ready(oRdy[1]),
    .so(oSo[1]), .so_valid(oVld[1]), .sof(oSof[1]), .eof(oEof[1])
  );

  piso_serializer #(.WIDTH(2), .MSB_FIRST(0), .IDLE_LEVEL(1)) u2 (
    .clk(clk), .rst(rst), .shift_en(shiftEn), .flush(flush),
    .in_valid(inValid), .in_data(dIn[2][1:0]), .in_ready(oRdy[2]),
    .so(oSo[2]), .so_valid(oVld[2]), .sof(oSof[2]), .eof(oEof[2])
  );

  // Expected outputs derived from the model's word/index view.
  function automatic logic expReady(input int k);
    return !rst && !flush && (!mBusy[k] || (shiftEn && (mIdx[k] == mW[k] - 1)));
  endfunction

  function automatic logic expSo(input int k);
    if (!mBusy[k]) return mIdle[k];
    return mMsb[k] ? mWord[k][mW[k] - 1 - mIdx[k]] : mWord[k][mIdx[k]];
  endfunction

  function automatic logic expSof(input int k);
    return mBusy[k] && (mIdx[k] == 0);
  endfunction

  function automatic logic expEof(input int k);
    return mBusy[k] && (mIdx[k] == mW[k] - 1);
  endfunction

  // Model advance: flush aborts, an accepted word restarts at index 0,
  // otherwise a tick walks the index and retires the word after the last bit.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        mBusy[k] <= 1'b0;
        mIdx[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (flush) begin
          mBusy[k] <= 1'b0;
        end else if (expReady(k) && inValid) begin
          mBusy[k] <= 1'b1;
          mWord[k] <= dIn[k];
          mIdx[k]  <= 0;
        end else if (mBusy[k] && shiftEn) begin
          if (mIdx[k] == mW[k] - 1) mBusy[k] <= 1'b0;
          else mIdx[k] <= mIdx[k] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("rdy[%0d]", k), oRdy[k], expReady(k));
        checkOutput($sformatf("so[%0d]", k), oSo[k], expSo(k));
        checkOutput($sformatf("vld[%0d]", k), oVld[k], mBusy[k]);
        checkOutput($sformatf("sof[%0d]", k), oSof[k], expSof(k));
        checkOutput($sformatf("eof[%0d]", k), oEof[k], expEof(k));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic se, input logic fl, input logic [7:0] d);
    inValid = v;
    shiftEn = se;
    flush   = fl;
    dIn[0]  = d;
    dIn[1]  = d;
    dIn[2]  = d;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  logic [7:0]  wordA5;
  logic [15:0] word2;
  logic [7:0]  wordC3;
  logic [7:0]  word3C;
  logic [7:0]  word81;

  initial begin
    wordA5 = 8'hA5;
    word2  = 16'hFF01;
    wordC3 = 8'hC3;
    word3C = 8'h3C;
    word81 = 8'h81;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    // Reset state
    #3;
    checkOutput("rst_rdy0", oRdy[0], 1'b0);
    checkOutput("rst_vld0", oVld[0], 1'b0);
    checkOutput("rst_so0", oSo[0], 1'b0);
    checkOutput("rst_sof0", oSof[0], 1'b0);
    checkOutput("rst_eof0", oEof[0], 1'b0);
    checkOutput("rst_so2_idle1", oSo[2], 1'b1);
    checkEn = 1'b1;
    stepCycle();
    rst = 1'b0;
    stepCycle();

    // Single word 0xA5, LSB-first, shift every cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5);
    #2;
    checkOutput("t1_idle_rdy", oRdy[0], 1'b1);
    stepCycle();
    inValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #2;
      checkOutput($sformatf("t1_so_bit%0d", i), oSo[0], wordA5[i]);
      checkOutput($sformatf("t1_model_bit%0d", i), expSo(0), wordA5[i]);
      checkOutput($sformatf("t1_sof_bit%0d", i), oSof[0], (i == 0));
      checkOutput($sformatf("t1_eof_bit%0d", i), oEof[0], (i == 7));
      stepCycle();
    end
    #2;
    checkOutput("t1_end_vld", oVld[0], 1'b0);
    checkOutput("t1_end_so", oSo[0], 1'b0);
    stepCycle();

    // Back-to-back 0x01 then 0xFF with in_valid held
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h01);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < 16; i++) begin
      #2;
      checkOutput($sformatf("t2_so_%0d", i), oSo[0], word2[i]);
      checkOutput($sformatf("t2_vld_%0d", i), oVld[0], 1'b1);
      checkOutput($sformatf("t2_sof_%0d", i), oSof[0], (i == 0 || i == 8));
      checkOutput($sformatf("t2_eof_%0d", i), oEof[0], (i == 7 || i == 15));
      if (i == 8) inValid = 1'b0;
      stepCycle();
    end
    #2;
    checkOutput("t2_end_vld", oVld[0], 1'b0);
    stepCycle();

    // MSB-first 0xC3 with shift_en every third cycle
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hC3);
    stepCycle();
    inValid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      shiftEn = ((c % 3) == 2);
      #2;
      checkOutput($sformatf("t3_so_c%0d", c), oSo[1], wordC3[7 - c / 3]);
      checkOutput($sformatf("t3_rdy_c%0d", c), oRdy[1], (c == 23));
      stepCycle();
    end
    shiftEn = 1'b0;
    #2;
    checkOutput("t3_end_vld", oVld[1], 1'b0);
    stepCycle();

    // Async reset during bit 4 of 0xA5, then 0x3C from bit 0
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5);
    stepCycle();
    inValid = 1'b0;
    repeat (4) stepCycle();
    checkOutput("t4_bit4_before_rst", oSo[0], wordA5[4]);
    #1 rst = 1'b1;
    #1;
    checkOutput("t4_rst_so", oSo[0], 1'b0);
    checkOutput("t4_rst_vld", oVld[0], 1'b0);
    checkOutput("t4_rst_rdy", oRdy[0], 1'b0);
    stepCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C);
    stepCycle();
    inValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #2;
      checkOutput($sformatf("t4_so_bit%0d", i), oSo[0], word3C[i]);
      stepCycle();
    end

    // Flush on bit 2 together with a pending word
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5);
    stepCycle();
    inValid = 1'b0;
    repeat (2) stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h81);
    #2;
    checkOutput("t5_flush_rdy", oRdy[0], 1'b0);
    stepCycle();
    flush = 1'b0;
    #2;
    checkOutput("t5_idle_vld", oVld[0], 1'b0);
    checkOutput("t5_idle_so", oSo[0], 1'b0);
    stepCycle();
    inValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #2;
      checkOutput($sformatf("t5_so_bit%0d", i), oSo[0], word81[i]);
      stepCycle();
    end

    // WIDTH=2 instance, idle level 1, word 2'b10
    #2;
    checkOutput("t6_idle_so", oSo[2], 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h02);
    stepCycle();
    inValid = 1'b0;
    #2;
    checkOutput("t6_so0", oSo[2], 1'b0);
    checkOutput("t6_sof0", oSof[2], 1'b1);
    checkOutput("t6_eof0", oEof[2], 1'b0);
    stepCycle();
    #2;
    checkOutput("t6_so1", oSo[2], 1'b1);
    checkOutput("t6_sof1", oSof[2], 1'b0);
    checkOutput("t6_eof1", oEof[2], 1'b1);
    stepCycle();
    #2;
    checkOutput("t6_end_so", oSo[2], 1'b1);
    checkOutput("t6_end_vld", oVld[2], 1'b0);
    stepCycle();

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      shiftEn = ($urandom_range(0, 3) != 0);
      inValid = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 40) == 0);
      rst     = ($urandom_range(0, 300) == 0);
      dIn[0]  = 8'($urandom);
      dIn[1]  = 8'($urandom);
      dIn[2]  = 8'($urandom);
      stepCycle();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    stepCycle();
    stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
